// File: rtl/me_frame_scheduler.sv
// Purpose: raster-order frame sequencer driving the motion_estimator core one 16x16 block at a time.
// Latency: load_done to res_valid is 1 (ISSUE) + core time + 1 (capture) + >=1 (DRAIN) cycles.
// Backpressure: a result is held stable in OUTPUT until res_ready; the next block waits for the handshake.
//
// Optional build macro: ME_SCHED_TIMEOUT_EN adds a per-block WAIT watchdog (TIMEOUT_CYC cycles)
// and a sticky timeout_err. Without it WAIT is unbounded and timeout_err is tied low.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   frame_start          one-cycle frame request, honoured only in IDLE outside the frame_done cycle
//   load_req/load_done   window-load handshake for blk_x/blk_y
//   me_start/me_*        motion_estimator control and result inputs
//   res_*                result valid/ready channel (block coordinate, motion vector, distortion)
//   frame_min_dist       running minimum of accepted res_dist over the current frame
//   busy, frame_done     status: not idle / one-cycle end-of-frame pulse
//   timeout_err          sticky watchdog flag
module me_frame_scheduler #(
    parameter int BLK_COLS    = 4,
    parameter int BLK_ROWS    = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       load_done,
    input  logic       me_completed,
    input  logic [3:0] me_motion_x,
    input  logic [3:0] me_motion_y,
    input  logic [7:0] me_best_dist,
    output logic       me_start,
    output logic [3:0] blk_x,
    output logic [3:0] blk_y,
    output logic       load_req,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_blk_x,
    output logic [3:0] res_blk_y,
    output logic [3:0] res_mv_x,
    output logic [3:0] res_mv_y,
    output logic [7:0] res_dist,
    output logic [7:0] frame_min_dist,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        DRAIN   = 3'd4,
        OUTPUT  = 3'd5,
        ADVANCE = 3'd6
    } state_t;

    localparam logic [3:0] LAST_X = 4'(BLK_COLS - 1);
    localparam logic [3:0] LAST_Y = 4'(BLK_ROWS - 1);

    if (BLK_COLS < 1 || BLK_COLS > 16 || BLK_ROWS < 1 || BLK_ROWS > 16 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("me_frame_scheduler: parameter out of range");
    end

    state_t state;
    state_t state_nxt;
    logic   last_blk;
    logic   frame_accept;
    logic   wait_expire;

    assign last_blk = (blk_x == LAST_X) && (blk_y == LAST_Y);
    // A request landing in the frame_done cycle is dropped; IDLE accepts from the next cycle.
    assign frame_accept = (state == IDLE) && frame_start && !frame_done;

`ifdef ME_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wait_cnt;
    logic        to_err_q;

    // Expires during the TIMEOUT_CYC-th WAIT cycle, i.e. as the count would reach TIMEOUT_CYC.
    assign wait_expire = (state == WAIT) && !me_completed && (wait_cnt == TO_LAST);
    assign timeout_err = to_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 16'd0;
            to_err_q <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= 16'd0;
            end else if (state == WAIT && !me_completed) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (wait_expire) begin
                to_err_q <= 1'b1;
            end
        end
    end
`else
    assign wait_expire = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        me_start  = 1'b0;
        load_req  = 1'b0;
        res_valid = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (frame_accept) state_nxt = LOAD;
            end
            LOAD: begin
                load_req = 1'b1;
                if (load_done) state_nxt = ISSUE;
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                me_start = 1'b1;
                if (me_completed || wait_expire) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Wait out a lingering completed so it cannot be mistaken for the next block.
                if (!me_completed) state_nxt = OUTPUT;
            end
            OUTPUT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ADVANCE;
            end
            ADVANCE: begin
                state_nxt = last_blk ? IDLE : LOAD;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_x          <= 4'd0;
            blk_y          <= 4'd0;
            res_blk_x      <= 4'd0;
            res_blk_y      <= 4'd0;
            res_mv_x       <= 4'd0;
            res_mv_y       <= 4'd0;
            res_dist       <= 8'd0;
            frame_min_dist <= 8'hFF;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_accept) begin
                        blk_x          <= 4'd0;
                        blk_y          <= 4'd0;
                        frame_min_dist <= 8'hFF;
                    end
                end
                WAIT: begin
                    if (me_completed) begin
                        res_blk_x <= blk_x;
                        res_blk_y <= blk_y;
                        res_mv_x  <= me_motion_x;
                        res_mv_y  <= me_motion_y;
                        res_dist  <= me_best_dist;
                    end else if (wait_expire) begin
                        // Timed-out block still yields a result: zero vector, worst distortion.
                        res_blk_x <= blk_x;
                        res_blk_y <= blk_y;
                        res_mv_x  <= 4'd0;
                        res_mv_y  <= 4'd0;
                        res_dist  <= 8'hFF;
                    end
                end
                OUTPUT: begin
                    if (res_ready && (res_dist < frame_min_dist)) begin
                        frame_min_dist <= res_dist;
                    end
                end
                ADVANCE: begin
                    if (blk_x == LAST_X) begin
                        blk_x <= 4'd0;
                        blk_y <= (blk_y == LAST_Y) ? 4'd0 : blk_y + 4'd1;
                    end else begin
                        blk_x <= blk_x + 4'd1;
                    end
                    frame_done <= last_blk;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
